donkey_ctl: RTL and testbench
=============================

# donkey_ctl

Per-frame movement controller for the donkey sprite. Samples player controls, runs a walk/jump/fall state machine once per frame at the rising edge of vertical blanking, and produces the sprite's top-left position plus a mirror flag. Sits directly upstream of the donkey draw stage, which uses `xpos`/`ypos` in place of fixed offsets and `mirror` to select the reversed ROM address.

## Interface
Parameters:
- `X_INIT`, 10: reset x position (pixels)
- `Y_GROUND`, 640: ground-level y of sprite top edge
- `X_MAX`, 976: rightmost legal x (1024 − 48 sprite width)
- `STEP`, 4: horizontal pixels per frame
- `JUMP_V`, 16: initial upward velocity (pixels/frame)
- `V_MAX`, 16: fall velocity cap
- `GRAVITY`, 1: velocity change per frame

Ports:
- `clk`  in  1: pixel clock
- `rst`  in  1: synchronous, active-high reset
- `vblnk`  in  1: vertical blanking from VGA timing
- `left`  in  1: move-left level
- `right`  in  1: move-right level
- `jump`  in  1: jump button level
- `xpos`  out  11: sprite left edge
- `ypos`  out  11: sprite top edge
- `mirror`  out  1: 1 = facing left
- `airborne`  out  1: 1 in JUMP or FALL

One clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- Frame tick: `tick` = `vblnk & ~vblnk_q`. All position/state updates occur only on `tick` cycles.
- Jump request: rising edge of `jump` (any cycle) sets `jump_req`. `jump_req` clears at the next tick, whether consumed or not. Holding `jump` never re-triggers.
- Horizontal, every tick and in every state: `left & ~right` → x = max(x − STEP, 0), `mirror` = 1; `right & ~left` → x = min(x + STEP, X_MAX), `mirror` = 0; both or neither → x and `mirror` unchanged.
- States (enum): GROUND, JUMP, FALL.
  - GROUND: on tick with `jump_req` → JUMP, vel = JUMP_V. y stays Y_GROUND.
  - JUMP: on tick, if vel > y → y = 0, vel = 0, → FALL. Otherwise y −= vel, vel −= GRAVITY. If the new vel is 0 → FALL.
  - FALL: on tick, vel = min(vel + GRAVITY, V_MAX). If y + vel ≥ Y_GROUND → y = Y_GROUND, vel = 0, → GROUND. Otherwise y += vel.
- A `jump_req` arriving while airborne is discarded at the next tick (no double jump).
- All arithmetic is in 11-bit unsigned; comparisons are done before subtraction, so no wrap-around.

## Timing
- Reset values: `xpos` = X_INIT, `ypos` = Y_GROUND, `mirror` = 0, `airborne` = 0, state GROUND, vel = 0, `jump_req` = 0, `vblnk_q` = 0.
- Outputs are registered. They change on the clock edge at which `tick` is high and are visible the cycle after. They are stable for the whole active frame.
- `jump` edge in the same cycle as `tick` counts for that tick.
- `rst` mid-jump: all registers return to reset values on that edge, regardless of `tick`.
- `airborne` is a registered decode of the next state, aligned with `ypos`.

## Structure
- Add `HOR_PIXELS` (1024), `SPRITE_W` (48), and `SPRITE_H` (64) to `vga_pkg`. Default `X_MAX` = HOR_PIXELS − SPRITE_W.
- The state enum `donkey_state_t` (GROUND, JUMP, FALL) lives in a new shared `game_pkg`, to be reused by the kong controller.
- One sub-module, `edge_det`, provides a registered rising-edge detector. It is instantiated twice: for `vblnk` and for `jump`.

## Test plan
- Reset, then 3 frames with no input → `xpos` = 10, `ypos` = 640, `mirror` = 0, `airborne` = 0 throughout.
- `right` held 5 frames → `xpos` 30, `mirror` 0. Then `left` held 10 frames → `xpos` clamps to 0, `mirror` 1. Then `left` & `right` together → no change.
- From x = 970, `right` held 3 frames → 974, 976, 976 (saturates at X_MAX).
- `jump` pulse mid-frame → next tick `ypos` 624, then 609, 595, and so on. Reaches apex 504 after 16 ticks with `airborne` = 1, falls, and lands at exactly 640 with `airborne` back to 0. `jump` held for the whole sequence does not re-jump.
- `jump` pulsed again while airborne → trajectory unchanged.
- `rst` asserted at frame 5 of a jump → next cycle `ypos` = 640, `xpos` = 10, state GROUND.

Source files
------------

// File: rtl/game_pkg.sv
// Purpose: game-logic types shared by the donkey and kong controllers.
// Ports: none (package).
package game_pkg;

    // Width of sprite positions and velocities
    localparam int unsigned POS_W = 11;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        FALL   = 2'd2
    } donkey_state_t;

endpackage : game_pkg

// File: rtl/vga_pkg.sv
// Purpose: shared VGA screen and sprite geometry constants.
// Ports: none (package).
package vga_pkg;

    localparam int unsigned HOR_PIXELS = 1024;
    localparam int unsigned SPRITE_W   = 48;
    localparam int unsigned SPRITE_H   = 64;

endpackage : vga_pkg

// File: rtl/edge_det.sv
// Purpose: rising-edge detector; registers the input once and flags a
//          0->1 transition in the same cycle the new level is seen.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   i_sig    in  level to watch
//   o_rise_c out combinational pulse, high for one cycle on a rising edge
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise_c
);

    logic r_sig_q;

    // Previous-cycle copy of the input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise_c = i_sig & ~r_sig_q;

endmodule : edge_det

// File: rtl/donkey_ctl.sv
// Purpose: per-frame movement controller for the donkey sprite. Samples
//          player controls and advances a walk/jump/fall state machine once
//          per frame on the rising edge of vertical blanking.
// Ports:
//   clk      in   pixel clock
//   rst      in   synchronous active-high reset
//   vblnk    in   vertical blanking from VGA timing
//   left     in   move-left level
//   right    in   move-right level
//   jump     in   jump button level
//   xpos     out  sprite left edge (11 bits)
//   ypos     out  sprite top edge (11 bits)
//   mirror   out  1 = facing left
//   airborne out  1 while jumping or falling
module donkey_ctl
    import game_pkg::*;
#(
    parameter int unsigned X_INIT   = 10,
    parameter int unsigned Y_GROUND = 640,
    parameter int unsigned X_MAX    = vga_pkg::HOR_PIXELS - vga_pkg::SPRITE_W,
    parameter int unsigned STEP     = 4,
    parameter int unsigned JUMP_V   = 16,
    parameter int unsigned V_MAX    = 16,
    parameter int unsigned GRAVITY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblnk,
    input  logic              left,
    input  logic              right,
    input  logic              jump,
    output logic [POS_W-1:0]  xpos,
    output logic [POS_W-1:0]  ypos,
    output logic              mirror,
    output logic              airborne
);

    // One extra bit so sums can be compared against limits without wrapping
    localparam int unsigned CW = POS_W + 1;

    donkey_state_t     r_state;
    donkey_state_t     w_state_nxt;
    logic [POS_W-1:0]  r_x;
    logic [POS_W-1:0]  r_y;
    logic [POS_W-1:0]  r_vel;
    logic [POS_W-1:0]  w_x_nxt;
    logic [POS_W-1:0]  w_y_nxt;
    logic [POS_W-1:0]  w_vel_nxt;
    logic              r_mirror;
    logic              w_mirror_nxt;
    logic              r_airborne;
    logic              r_jump_req;
    logic              w_jump_req_nxt;
    logic              w_jump_req_eff;
    logic              w_tick;
    logic              w_jump_rise;
    logic [CW-1:0]     w_x_inc;
    logic [CW-1:0]     w_fall_raw;
    logic [CW-1:0]     w_fall_vel;
    logic [CW-1:0]     w_fall_y;

    edge_det u_vblnk_edge (
        .clk      (clk),
        .rst      (rst),
        .i_sig    (vblnk),
        .o_rise_c (w_tick)
    );

    edge_det u_jump_edge (
        .clk      (clk),
        .rst      (rst),
        .i_sig    (jump),
        .o_rise_c (w_jump_rise)
    );

    // An edge on the tick cycle itself counts for that tick
    assign w_jump_req_eff = r_jump_req | w_jump_rise;

    assign w_x_inc    = CW'(r_x) + CW'(STEP);
    assign w_fall_raw = CW'(r_vel) + CW'(GRAVITY);
    assign w_fall_vel = (w_fall_raw > CW'(V_MAX)) ? CW'(V_MAX) : w_fall_raw;
    assign w_fall_y   = CW'(r_y) + w_fall_vel;

    // Jump request: latched on edge, dropped at every tick
    always_comb begin
        w_jump_req_nxt = r_jump_req;
        if (w_tick) begin
            w_jump_req_nxt = 1'b0;
        end else if (w_jump_rise) begin
            w_jump_req_nxt = 1'b1;
        end
    end

    // Horizontal motion, independent of vertical state
    always_comb begin
        w_x_nxt      = r_x;
        w_mirror_nxt = r_mirror;
        if (w_tick) begin
            if (left && !right) begin
                w_mirror_nxt = 1'b1;
                if (r_x < POS_W'(STEP)) begin
                    w_x_nxt = '0;
                end else begin
                    w_x_nxt = r_x - POS_W'(STEP);
                end
            end else if (right && !left) begin
                w_mirror_nxt = 1'b0;
                if (w_x_inc > CW'(X_MAX)) begin
                    w_x_nxt = POS_W'(X_MAX);
                end else begin
                    w_x_nxt = w_x_inc[POS_W-1:0];
                end
            end
        end
    end

    // Vertical state machine: next state, y and velocity
    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_vel_nxt   = r_vel;
        if (w_tick) begin
            case (r_state)
                GROUND: begin
                    if (w_jump_req_eff) begin
                        w_state_nxt = JUMP;
                        w_vel_nxt   = POS_W'(JUMP_V);
                    end
                end
                JUMP: begin
                    if (r_vel > r_y) begin
                        w_y_nxt     = '0;
                        w_vel_nxt   = '0;
                        w_state_nxt = FALL;
                    end else begin
                        w_y_nxt = r_y - r_vel;
                        // Apex reached when gravity consumes the remaining velocity
                        if (r_vel <= POS_W'(GRAVITY)) begin
                            w_vel_nxt   = '0;
                            w_state_nxt = FALL;
                        end else begin
                            w_vel_nxt = r_vel - POS_W'(GRAVITY);
                        end
                    end
                end
                FALL: begin
                    if (w_fall_y >= CW'(Y_GROUND)) begin
                        w_y_nxt     = POS_W'(Y_GROUND);
                        w_vel_nxt   = '0;
                        w_state_nxt = GROUND;
                    end else begin
                        w_y_nxt   = w_fall_y[POS_W-1:0];
                        w_vel_nxt = w_fall_vel[POS_W-1:0];
                    end
                end
                default: begin
                    w_state_nxt = GROUND;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= GROUND;
            r_x        <= POS_W'(X_INIT);
            r_y        <= POS_W'(Y_GROUND);
            r_vel      <= '0;
            r_mirror   <= 1'b0;
            r_airborne <= 1'b0;
            r_jump_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_vel      <= w_vel_nxt;
            r_mirror   <= w_mirror_nxt;
            r_airborne <= (w_state_nxt != GROUND);
            r_jump_req <= w_jump_req_nxt;
        end
    end

    assign xpos     = r_x;
    assign ypos     = r_y;
    assign mirror   = r_mirror;
    assign airborne = r_airborne;

endmodule : donkey_ctl

// File: tb/tb_donkey_ctl.sv
// Purpose: directed self-checking bench for donkey_ctl.
module tb_donkey_ctl;

    logic        clk;
    logic        rst;
    logic        vblnk;
    logic        left;
    logic        right;
    logic        jump;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        mirror;
    logic        airborne;

    int n_cmp;
    int n_err;

    // Expected jump trajectory, one entry per tick after the request
    int exp_y   [0:32];
    int exp_air [0:32];

    donkey_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .vblnk    (vblnk),
        .left     (left),
        .right    (right),
        .jump     (jump),
        .xpos     (xpos),
        .ypos     (ypos),
        .mirror   (mirror),
        .airborne (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One frame: vblnk rises (tick), then active video for a few cycles
    task automatic frame();
        @(negedge clk) vblnk = 1'b1;
        @(negedge clk) vblnk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_jump();
        @(negedge clk) jump = 1'b1;
        @(negedge clk) jump = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        vblnk = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        jump  = 1'b0;

        // Rise 16,15,...,1 then fall 1,2,...,16; index 0 is the launch tick
        exp_y[0]   = 640;
        exp_air[0] = 1;
        for (int k = 1; k <= 16; k++) begin
            exp_y[k]   = 640 - (k * (33 - k)) / 2;
            exp_air[k] = 1;
        end
        for (int j = 1; j <= 16; j++) begin
            exp_y[16 + j]   = 504 + (j * (j + 1)) / 2;
            exp_air[16 + j] = (j == 16) ? 0 : 1;
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_x", int'(xpos), 10);
        check("rst_y", int'(ypos), 640);
        check("rst_mirror", int'(mirror), 0);
        check("rst_air", int'(airborne), 0);

        // Idle frames
        for (int f = 0; f < 3; f++) begin
            frame();
            check("idle_x", int'(xpos), 10);
            check("idle_y", int'(ypos), 640);
            check("idle_air", int'(airborne), 0);
        end

        // Walk right 5 frames
        right = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            frame();
            check("right_x", int'(xpos), 10 + 4 * f);
        end
        check("right_mirror", int'(mirror), 0);

        // Walk left 10 frames, clamping at 0
        right = 1'b0;
        left  = 1'b1;
        for (int f = 1; f <= 10; f++) begin
            frame();
            check("left_x", int'(xpos), (30 - 4 * f < 0) ? 0 : 30 - 4 * f);
            check("left_mirror", int'(mirror), 1);
        end

        // Both pressed: hold position and facing
        right = 1'b1;
        for (int f = 0; f < 2; f++) begin
            frame();
            check("both_x", int'(xpos), 0);
            check("both_mirror", int'(mirror), 1);
        end
        left  = 1'b0;
        right = 1'b0;

        // Walk from 10 to 970, then saturate at X_MAX
        do_reset();
        right = 1'b1;
        repeat (240) frame();
        check("walk_970", int'(xpos), 970);
        frame();
        check("sat_x1", int'(xpos), 974);
        frame();
        check("sat_x2", int'(xpos), 976);
        frame();
        check("sat_x3", int'(xpos), 976);
        check("sat_mirror", int'(mirror), 0);
        right = 1'b0;

        // Full jump with jump held throughout
        do_reset();
        @(negedge clk) jump = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            frame();
            check($sformatf("jump_y[%0d]", i), int'(ypos), exp_y[i]);
            check($sformatf("jump_air[%0d]", i), int'(airborne), exp_air[i]);
        end
        check("jump_y1_624", int'(ypos) == 640 ? exp_y[1] : -1, 624);
        for (int f = 0; f < 3; f++) begin
            frame();
            check("held_no_rejump_y", int'(ypos), 640);
            check("held_no_rejump_air", int'(airborne), 0);
        end
        jump = 1'b0;
        @(negedge clk);

        // Second press while airborne is ignored
        do_reset();
        pulse_jump();
        for (int i = 0; i <= 32; i++) begin
            if (i == 3 || i == 20) pulse_jump();
            frame();
            check($sformatf("dbl_y[%0d]", i), int'(ypos), exp_y[i]);
            check($sformatf("dbl_air[%0d]", i), int'(airborne), exp_air[i]);
        end
        frame();
        check("dbl_land_y", int'(ypos), 640);
        check("dbl_land_air", int'(airborne), 0);
        check("dbl_x", int'(xpos), 10);

        // Jump edge on the tick cycle counts for that tick
        do_reset();
        @(negedge clk);
        vblnk = 1'b1;
        jump  = 1'b1;
        @(negedge clk);
        vblnk = 1'b0;
        jump  = 1'b0;
        repeat (3) @(negedge clk);
        check("same_cyc_air", int'(airborne), 1);
        check("same_cyc_y", int'(ypos), 640);
        frame();
        check("same_cyc_y2", int'(ypos), 624);

        // Reset in the middle of a jump while walking right
        do_reset();
        right = 1'b1;
        pulse_jump();
        for (int i = 0; i <= 4; i++) frame();
        check("mid_y", int'(ypos), 582);
        check("mid_x", int'(xpos), 30);
        check("mid_air", int'(airborne), 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        right = 1'b0;
        check("mid_rst_x", int'(xpos), 10);
        check("mid_rst_y", int'(ypos), 640);
        check("mid_rst_air", int'(airborne), 0);
        check("mid_rst_mirror", int'(mirror), 0);
        frame();
        check("mid_rst_ground_y", int'(ypos), 640);
        check("mid_rst_ground_air", int'(airborne), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_donkey_ctl
